// File: rtl/twinstick_pkg.sv
// twinstick_pkg: direction nibble type, bit/slot indices and direction helpers
package twinstick_pkg;

    typedef logic [3:0] dir4_t;

    localparam int DIR_U = 3;
    localparam int DIR_D = 2;
    localparam int DIR_L = 1;
    localparam int DIR_R = 0;

    localparam int SLOT_DL = 3;
    localparam int SLOT_DR = 2;
    localparam int SLOT_UL = 1;
    localparam int SLOT_UR = 0;

    // Opposing cardinals cancel so the core never sees U+D or L+R.
    function automatic dir4_t lockout(input dir4_t d);
        dir4_t r;
        r[DIR_U] = d[DIR_U] & ~d[DIR_D];
        r[DIR_D] = d[DIR_D] & ~d[DIR_U];
        r[DIR_L] = d[DIR_L] & ~d[DIR_R];
        r[DIR_R] = d[DIR_R] & ~d[DIR_L];
        return r;
    endfunction

    // Place cardinals into output slots; rotated mode needs both cardinals of a diagonal.
    function automatic dir4_t remap(input dir4_t d, input logic rot);
        dir4_t r;
        r[SLOT_DL] = rot ? d[DIR_D] & d[DIR_L] : d[DIR_D];
        r[SLOT_DR] = rot ? d[DIR_D] & d[DIR_R] : d[DIR_R];
        r[SLOT_UL] = rot ? d[DIR_U] & d[DIR_L] : d[DIR_L];
        r[SLOT_UR] = rot ? d[DIR_U] & d[DIR_R] : d[DIR_U];
        return r;
    endfunction

endpackage

// File: rtl/twinstick_input_mapper_axis_hyst.sv
// axis_hyst: one signed 8-bit stick axis to registered hysteretic {neg,pos} flags
module axis_hyst
    import twinstick_pkg::*;
#(
    parameter int THRESH = 20,
    parameter int HYST   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic signed [7:0] v_i,
    output logic              neg_o,
    output logic              pos_o
);

    localparam int REL = THRESH - HYST;

    int   v;
    logic neg_d, neg_q, pos_d, pos_q;

    // Engage beyond THRESH, release only once back inside THRESH-HYST; -128 stays negative.
    always_comb begin
        v     = int'(v_i);
        neg_d = (v < -THRESH) || (neg_q && !(v > -REL));
        pos_d = (v > THRESH) || (pos_q && !(v < REL));
    end

    // Flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            neg_q <= 1'b0;
            pos_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
            pos_q <= pos_d;
        end
    end

    assign neg_o = neg_q;
    assign pos_o = pos_q;

endmodule

// File: rtl/twinstick_input_mapper.sv
// twinstick_input_mapper: per-player run/aim/fire conditioning for twin-stick arcade cores
// Optional autofire square-wave gating is built when TWINSTICK_AUTOFIRE_EN is defined.
module twinstick_input_mapper
    import twinstick_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int THRESH      = 20,
    parameter int HYST        = 6,
    parameter int HOLD_CYCLES = 12000,
    parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
`ifdef TWINSTICK_AUTOFIRE_EN
    ,
    parameter int AUTO_PERIOD = 48000
`endif
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   aimfire_en,
    input  logic                   rot45,
    input  logic [3:0]             joy_dpad    [NUM_PLAYERS],
    input  logic [3:0]             joy_abtn    [NUM_PLAYERS],
    input  logic [NUM_PLAYERS-1:0] joy_fire,
    input  logic [15:0]            ana_l       [NUM_PLAYERS],
    input  logic [15:0]            ana_r       [NUM_PLAYERS],
    output logic [3:0]             run_out     [NUM_PLAYERS],
    output logic [3:0]             aim_out     [NUM_PLAYERS],
    output logic [NUM_PLAYERS-1:0] trigger_out
);

    logic [3:0]             neg_w  [NUM_PLAYERS];
    logic [3:0]             pos_w  [NUM_PLAYERS];
    dir4_t                  dpad_q [NUM_PLAYERS];
    dir4_t                  abtn_q [NUM_PLAYERS];
    dir4_t                  run_d  [NUM_PLAYERS];
    dir4_t                  run_q  [NUM_PLAYERS];
    dir4_t                  aim_d  [NUM_PLAYERS];
    dir4_t                  aim_q  [NUM_PLAYERS];
    logic [HOLD_W-1:0]      cnt_d  [NUM_PLAYERS];
    logic [HOLD_W-1:0]      cnt_q  [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] fire1_q, fire2_q, trig_d, trig_q;
    logic                   en_q, gate;
    dir4_t                  al, ar;

    // Axis order per player: 0 left X, 1 left Y, 2 right X, 3 right Y.
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
        for (genvar i = 0; i < 4; i++) begin : g_ax
            axis_hyst #(.THRESH(THRESH), .HYST(HYST)) u_ax (
                .clk_i (clk_sys),
                .rst_i (reset),
                .v_i   (i < 2 ? ana_l[p][(i % 2) * 8 +: 8] : ana_r[p][(i % 2) * 8 +: 8]),
                .neg_o (neg_w[p][i]),
                .pos_o (pos_w[p][i])
            );
        end
    end

`ifdef TWINSTICK_AUTOFIRE_EN
    localparam int PH_W = $clog2(AUTO_PERIOD);
    logic [PH_W-1:0] phase_q;
    // Shared free-running phase; upper half of the period lets the trigger through.
    always_ff @(posedge clk_sys) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_q == PH_W'(AUTO_PERIOD - 1) ? '0 : phase_q + PH_W'(1);
    end
    assign gate = phase_q >= PH_W'(AUTO_PERIOD / 2);
`else
    assign gate = 1'b1;
`endif

    // Stage-2 source select/lockout/remap and the aim-fire hold counter.
    always_comb begin
        al = '0;
        ar = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            al        = {neg_w[p][1], pos_w[p][1], neg_w[p][0], pos_w[p][0]};
            ar        = {neg_w[p][3], pos_w[p][3], neg_w[p][2], pos_w[p][2]};
            run_d[p]  = remap(lockout(|al ? al : dpad_q[p]), rot45);
            aim_d[p]  = remap(lockout(ar | abtn_q[p]), rot45);
            cnt_d[p]  = (!aimfire_en || (aimfire_en != en_q)) ? '0 :
                        |aim_q[p] ? HOLD_W'(HOLD_CYCLES) :
                        |cnt_q[p] ? cnt_q[p] - HOLD_W'(1) : '0;
            trig_d[p] = gate & (fire2_q[p] | (aimfire_en & (|aim_q[p] | |cnt_q[p])));
        end
    end

    // Pipeline and per-player state registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            en_q    <= 1'b0;
            fire1_q <= '0;
            fire2_q <= '0;
            trig_q  <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                dpad_q[p] <= '0;
                abtn_q[p] <= '0;
                run_q[p]  <= '0;
                aim_q[p]  <= '0;
                cnt_q[p]  <= '0;
            end
        end else begin
            en_q    <= aimfire_en;
            fire1_q <= joy_fire;
            fire2_q <= fire1_q;
            trig_q  <= trig_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                dpad_q[p] <= joy_dpad[p];
                abtn_q[p] <= joy_abtn[p];
                run_q[p]  <= run_d[p];
                aim_q[p]  <= aim_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    assign run_out     = run_q;
    assign aim_out     = aim_q;
    assign trigger_out = trig_q;

endmodule

// File: tb/tb_twinstick_input_mapper.sv
// tb_twinstick_input_mapper: directed checks of run/aim mapping, hysteresis and trigger timing
module tb_twinstick_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset, aimfire_en, rot45;
    logic [3:0]  joy_dpad [2];
    logic [3:0]  joy_abtn [2];
    logic [1:0]  joy_fire;
    logic [15:0] ana_l [2];
    logic [15:0] ana_r [2];
    logic [3:0]  run_out [2];
    logic [3:0]  aim_out [2];
    logic [1:0]  trigger_out;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk_sys = ~clk_sys;

    twinstick_input_mapper #(
        .NUM_PLAYERS (2),
        .THRESH      (20),
        .HYST        (6),
        .HOLD_CYCLES (5)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .aimfire_en  (aimfire_en),
        .rot45       (rot45),
        .joy_dpad    (joy_dpad),
        .joy_abtn    (joy_abtn),
        .joy_fire    (joy_fire),
        .ana_l       (ana_l),
        .ana_r       (ana_r),
        .run_out     (run_out),
        .aim_out     (aim_out),
        .trigger_out (trigger_out)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        aimfire_en = 1'b0;
        rot45      = 1'b0;
        joy_fire   = '0;
        for (int p = 0; p < 2; p++) begin
            joy_dpad[p] = '0;
            joy_abtn[p] = '0;
            ana_l[p]    = '0;
            ana_r[p]    = '0;
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step(2);
        for (int p = 0; p < 2; p++) begin
            vecs++;
            if (run_out[p] !== 4'b0 || aim_out[p] !== 4'b0 || trigger_out[p] !== 1'b0) begin
                errs++;
                $display("FAIL reset p%0d run=%b aim=%b trig=%b want 0/0/0", p, run_out[p], aim_out[p], trigger_out[p]);
            end
        end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_analog_ramp();
        logic [7:0] v  [5] = '{8'd25, 8'd16, 8'd13, 8'he7, 8'd0};
        logic [3:0] e1 [5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
        logic [3:0] e2 [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            ana_l[0] = {8'h00, v[i]};
            step(1);
            vecs++;
            if (run_out[0] !== e1[i]) begin
                errs++;
                $display("FAIL ramp x=%0d cyc1 run0=%b want %b", $signed(v[i]), run_out[0], e1[i]);
            end
            step(1);
            vecs++;
            if (run_out[0] !== e2[i] || run_out[1] !== 4'b0) begin
                errs++;
                $display("FAIL ramp x=%0d cyc2 run0=%b want %b run1=%b want 0000", $signed(v[i]), run_out[0], e2[i], run_out[1]);
            end
        end
    endtask

    task automatic test_dpad_rot();
        logic [3:0] d [6] = '{4'b1001, 4'b1001, 4'b0101, 4'b1000, 4'b0110, 4'b0010};
        logic       r [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] e [6] = '{4'b0001, 4'b0101, 4'b0100, 4'b0000, 4'b1000, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            joy_dpad[0] = d[i];
            rot45       = r[i];
            step(2);
            vecs++;
            if (run_out[0] !== e[i]) begin
                errs++;
                $display("FAIL dpad %b rot=%b run0=%b want %b", d[i], r[i], run_out[0], e[i]);
            end
        end
        rot45       = 1'b0;
        joy_dpad[0] = 4'b1000;
        ana_l[0]    = {8'h00, 8'd30};
        step(2);
        vecs++;
        if (run_out[0] !== 4'b0100) begin
            errs++;
            $display("FAIL analog_priority run0=%b want 0100", run_out[0]);
        end
        ana_l[0]    = '0;
        joy_dpad[0] = '0;
        step(2);
    endtask

    task automatic test_lockout();
        logic [3:0] d [4] = '{4'b1100, 4'b0011, 4'b1110, 4'b1011};
        logic [3:0] e [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0001};
        rot45       = 1'b0;
        joy_dpad[0] = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            joy_dpad[1] = d[i];
            step(2);
            vecs++;
            if (run_out[1] !== e[i] || run_out[0] !== 4'b0101) begin
                errs++;
                $display("FAIL lockout dpad1=%b run1=%b want %b run0=%b want 0101", d[i], run_out[1], e[i], run_out[0]);
            end
        end
        joy_abtn[0] = 4'b1100;
        step(2);
        vecs++;
        if (aim_out[0] !== 4'b0000) begin
            errs++;
            $display("FAIL lockout_aim aim0=%b want 0000", aim_out[0]);
        end
        idle();
        step(2);
    endtask

    task automatic test_aim_neg128();
        logic [7:0] y [3] = '{8'h80, 8'h7f, 8'h00};
        logic [3:0] e [3] = '{4'b0001, 4'b1000, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            ana_r[0] = {y[i], 8'h00};
            step(2);
            vecs++;
            if (aim_out[0] !== e[i] || aim_out[1] !== 4'b0) begin
                errs++;
                $display("FAIL aim y=%0d aim0=%b want %b aim1=%b want 0000", $signed(y[i]), aim_out[0], e[i], aim_out[1]);
            end
        end
    endtask

    task automatic test_fire_delay();
        aimfire_en  = 1'b0;
        joy_fire[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            joy_fire[0] = 1'b0;
            vecs++;
            if (trigger_out[0] !== (k == 3) || trigger_out[1] !== 1'b0) begin
                errs++;
                $display("FAIL fire_delay cyc%0d trig=%b want %b0", k, trigger_out, (k == 3));
            end
        end
    endtask

    task automatic test_aimfire_hold();
        aimfire_en = 1'b1;
        step(3);
        joy_abtn[1] = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            joy_abtn[1] = 4'b0;
            vecs++;
            if (trigger_out[1] !== (k >= 3 && k <= 8) || trigger_out[0] !== 1'b0) begin
                errs++;
                $display("FAIL aim_hold cyc%0d trig1=%b want %b trig0=%b want 0", k, trigger_out[1], (k >= 3 && k <= 8), trigger_out[0]);
            end
        end
        joy_fire[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            joy_fire[0] = 1'b0;
            vecs++;
            if (trigger_out[0] !== (k == 3)) begin
                errs++;
                $display("FAIL aim_fire_or cyc%0d trig0=%b want %b", k, trigger_out[0], (k == 3));
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        aimfire_en  = 1'b1;
        joy_abtn[0] = 4'b1000;
        step(3);
        vecs++;
        if (trigger_out[0] !== 1'b1) begin
            errs++;
            $display("FAIL hold_active trig0=%b want 1", trigger_out[0]);
        end
        joy_abtn[0] = 4'b0;
        step(2);
        reset = 1'b1;
        step(1);
        vecs++;
        if (trigger_out !== 2'b00 || aim_out[0] !== 4'b0 || run_out[0] !== 4'b0 || aim_out[1] !== 4'b0 || run_out[1] !== 4'b0) begin
            errs++;
            $display("FAIL reset_mid_hold trig=%b aim0=%b run0=%b want all 0", trigger_out, aim_out[0], run_out[0]);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            vecs++;
            if (trigger_out !== 2'b00 || aim_out[0] !== 4'b0) begin
                errs++;
                $display("FAIL post_reset cyc%0d trig=%b aim0=%b want 00/0000", k, trigger_out, aim_out[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_analog_ramp();
        test_dpad_rot();
        test_lockout();
        test_aim_neg128();
        test_fire_delay();
        test_aimfire_hold();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
